// File: rtl/fib_pkg.sv
// Shared definitions for the recursive-Fibonacci datapath and controllers.
// Holds the push-source encodings and the default word width / stack depth.
package fib_pkg;

    localparam int FIB_DATA_W = 16;
    localparam int FIB_DEPTH  = 32;

    typedef enum logic [1:0] {
        SRC_FLAG = 2'd0,
        SRC_N    = 2'd1,
        SRC_RET  = 2'd2,
        SRC_ZERO = 2'd3
    } push_src_e;

endpackage

// File: rtl/fib_stack_mem.sv
// Stack storage: DEPTH x DATA_W register array.
// Ports: clk; we/waddr/wdata synchronous write port; raddr/rdata
// asynchronous read port (driven by the parent with sp-1).
module fib_stack_mem
    import fib_pkg::*;
#(
    parameter int   DATA_W = FIB_DATA_W,
    parameter int   DEPTH  = FIB_DEPTH,
    localparam int  PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fib_stack.sv
// LIFO of call-frame words plus the flag / n / return-value frame
// registers loaded by the Fibonacci stack controller.
// Ports: clk, rst_n (sync, active low); push/pop strobes with push_src
// selecting flag_in / n_in / ret_in / zero; en_f/en_n/en_res load the
// frame registers from the current top word; clr_err clears the sticky
// errors. Outputs: flag_q, n_q, res_q, combinational top, count,
// empty, full, ovf_err, unf_err.
module fib_stack
    import fib_pkg::*;
#(
    parameter int   DATA_W = FIB_DATA_W,
    parameter int   DEPTH  = FIB_DEPTH,
    localparam int  PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [1:0]        push_src,
    input  logic              en_f,
    input  logic              en_n,
    input  logic              en_res,
    input  logic [DATA_W-1:0] flag_in,
    input  logic [DATA_W-1:0] n_in,
    input  logic [DATA_W-1:0] ret_in,
    input  logic              clr_err,
    output logic [DATA_W-1:0] flag_q,
    output logic [DATA_W-1:0] n_q,
    output logic [DATA_W-1:0] res_q,
    output logic [DATA_W-1:0] top,
    output logic [PTR_W:0]    count,
    output logic              empty,
    output logic              full,
    output logic              ovf_err,
    output logic              unf_err
);

    localparam logic [PTR_W:0] SP_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] SP_ONE  = (PTR_W+1)'(1);

    logic [PTR_W:0]    sp_q, sp_d, sp_m1;
    logic [DATA_W-1:0] flag_d, n_d, res_d;
    logic              ovf_d, unf_d;
    logic              is_empty, is_full;
    logic [DATA_W-1:0] push_word, rd_word;
    logic              mem_we;
    logic [PTR_W-1:0]  mem_waddr;

    assign sp_m1    = sp_q - SP_ONE;
    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == SP_FULL);

    fib_stack_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (push_word),
        .raddr (sp_m1[PTR_W-1:0]),
        .rdata (rd_word)
    );

    // Memory contents are not reset, so mask the read while empty.
    assign top = is_empty ? '0 : rd_word;

    always_comb begin
        push_word = '0;
        case (push_src_e'(push_src))
            SRC_FLAG: push_word = flag_in;
            SRC_N:    push_word = n_in;
            SRC_RET:  push_word = ret_in;
            SRC_ZERO: push_word = '0;
            default:  push_word = '0;
        endcase
    end

    always_comb begin
        sp_d      = sp_q;
        mem_we    = 1'b0;
        mem_waddr = sp_q[PTR_W-1:0];
        ovf_d     = ovf_err & ~clr_err;
        unf_d     = unf_err & ~clr_err;

        if (push && pop) begin
            if (!is_empty) begin
                // Replace in place: no pointer motion, so never an overflow.
                mem_we    = 1'b1;
                mem_waddr = sp_m1[PTR_W-1:0];
            end else begin
                // Nothing to pop; the push still lands (empty is never full).
                mem_we = 1'b1;
                sp_d   = sp_q + SP_ONE;
                unf_d  = 1'b1;
            end
        end else if (push) begin
            if (is_full) begin
                ovf_d = 1'b1;
            end else begin
                mem_we = 1'b1;
                sp_d   = sp_q + SP_ONE;
            end
        end else if (pop) begin
            if (is_empty) begin
                unf_d = 1'b1;
            end else begin
                sp_d = sp_m1;
            end
        end

        // Loads see top as it stands before the edge, so a same-cycle pop
        // captures the word being removed.
        flag_d = en_f   ? top : flag_q;
        n_d    = en_n   ? top : n_q;
        res_d  = en_res ? top : res_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_q    <= '0;
            flag_q  <= '0;
            n_q     <= '0;
            res_q   <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            flag_q  <= flag_d;
            n_q     <= n_d;
            res_q   <= res_d;
            ovf_err <= ovf_d;
            unf_err <= unf_d;
        end
    end

    assign count = sp_q;
    assign empty = is_empty;
    assign full  = is_full;

endmodule

// File: doc/fib_stack.md
Name: fib_stack

Overview:
- Stack datapath driven directly by the recursive-Fibonacci stack controller, downstream of it.
- Consumes the controller's push/pop strobes, push-source select and register enables.
- Holds a LIFO of call-frame words plus the three frame registers (flag, n, return value) that the controller loads on pops.
- Reports occupancy and sticky over/underflow errors to the top-level controller.

Parameters:
- DATA_W, 16, width of every stack word and frame register.
- DEPTH, 32, number of stack entries; must be a power of two, at least 4.
- PTR_W, $clog2(DEPTH), stack pointer index width (derived; not to be overridden).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- push  in  1  write selected source word onto the stack this cycle.
- pop  in  1  remove top-of-stack word this cycle.
- push_src  in  2  push source select: 0 = flag_in, 1 = n_in, 2 = ret_in, 3 = constant zero.
- en_f  in  1  load flag_q from the current top word.
- en_n  in  1  load n_q from the current top word.
- en_res  in  1  load res_q from the current top word.
- flag_in  in  DATA_W  flag word to push.
- n_in  in  DATA_W  n argument to push.
- ret_in  in  DATA_W  return value to push.
- clr_err  in  1  clear sticky error flags.
- flag_q  out  DATA_W  popped flag register.
- n_q  out  DATA_W  popped n register.
- res_q  out  DATA_W  popped return-value register.
- top  out  DATA_W  combinational top-of-stack word (mem[sp-1]); 0 when empty.
- count  out  PTR_W+1  number of valid entries, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- ovf_err  out  1  sticky: push attempted while full.
- unf_err  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (rst_n = 0 at clock edge): sp/count = 0; flag_q = n_q = res_q = 0; ovf_err = unf_err = 0. Memory contents are not reset; top reads 0 while empty. Reset overrides every other input in the same cycle, including mid push/pop sequences.
- Push only, not full: mem[sp] <= selected word; sp <= sp+1. Visible on top the next cycle.
- Push only, full: no write, sp unchanged; ovf_err <= 1.
- Pop only, not empty: sp <= sp-1.
- Pop only, empty: sp unchanged; unf_err <= 1.
- Push and pop together, not empty: replace top (mem[sp-1] <= selected word); sp unchanged; no error even when full.
- Push and pop together, empty: treated as push only; unf_err <= 1.
- Register enables: each of en_f, en_n, en_res loads its register from top as it stands before this edge.
  - Pop with an enable in the same cycle captures the word being removed; zero latency.
  - An enable without pop is a peek.
  - An enable while empty loads 0.
  - Enables are independent and may coincide.
- Errors: cleared by clr_err; a new error in the same cycle as clr_err wins (flag set).
- Arithmetic: sp is PTR_W+1 bits with no wrap; guards prevent the increment above DEPTH and the decrement below 0. Memory indexed by the low PTR_W bits.
- All outputs except top are registered; empty/full/count decode directly from sp.

Decomposition:
- Shared package fib_pkg holds:
  - push_src encodings: SRC_FLAG = 0, SRC_N = 1, SRC_RET = 2, SRC_ZERO = 3.
  - Default DATA_W/DEPTH constants, shared with the stack controller and top-level controller.
- One natural sub-module, fib_stack_mem: DEPTH x DATA_W register array with one synchronous write port and one asynchronous read port at address sp-1.
- Push mux, pointer logic, frame registers and error flags stay in fib_stack.

Test Plan:
- Reset, then push_src = 0 with flag_in = 1, push_src = 2 with ret_in = 0x0005, push_src = 1 with n_in = 0x0003 (one push per cycle) -> count = 3, top = 0x0003, empty = 0.
- From that state, pop+en_n, then pop+en_res, then pop+en_f on successive cycles -> n_q = 3, res_q = 5, flag_q = 1, count = 0, empty = 1, no errors.
- Push 32 words 0..31, then push 0xAAAA -> full = 1, ovf_err = 1, top = 31; then push+pop with n_in = 0x7777 -> top = 0x7777, count = 32.
- Empty stack, pop with en_f -> flag_q = 0, unf_err = 1, count = 0; clr_err -> unf_err = 0 next cycle.
- push_src = 3 with all data inputs = 0xFFFF -> top = 0; en_res without pop -> res_q = 0, count unchanged.
- Push 2 words, assert rst_n = 0 in the same cycle as a push -> count = 0, all registers 0, top = 0.
